// File: rtl/ivl_uvm_ovl_delta_stim_pkg.sv
// Shared types and helpers for the bounded-delta stimulus generator.
// Holds the run-control state encoding and the 16-bit Galois LFSR step function.
package ivl_uvm_ovl_delta_stim_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } stim_state_e;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Right-shifting Galois form: the bit shifted out folds the taps back in.
    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        logic [15:0] nxt;
        nxt = cur >> 1;
        if (cur[0]) begin
            nxt = nxt ^ LFSR_TAPS;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/ivl_uvm_ovl_lfsr16.sv
// 16-bit Galois LFSR that moves one state only when asked to.
// Reset is synchronous and active-high; SEED must be non-zero.
module ivl_uvm_ovl_lfsr16
    import ivl_uvm_ovl_delta_stim_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        advance,
    output logic [15:0] state
);

    logic [15:0] state_q;
    logic [15:0] state_d;

    // Next state: advance by one LFSR step or hold.
    always_comb begin
        state_d = state_q;
        if (advance) begin
            state_d = lfsr_next(state_q);
        end
    end

    // State register, reloaded with the seed on reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/ivl_uvm_ovl_delta_stim_gen.sv
// Bounded-delta stimulus generator: walks test_expr through a non-wrapping sequence whose
// non-zero steps all have magnitude in [MIN_DELTA, MAX_DELTA], step size and direction
// picked from an LFSR. Start/done handshake, enable/hold gating.
// Optional violation injection is compiled in with IVL_UVM_OVL_DELTA_STIM_VIOL_INJ_EN:
// it adds inj_viol/viol_flag and lets a step use MAX_DELTA+1.
module ivl_uvm_ovl_delta_stim_gen
    import ivl_uvm_ovl_delta_stim_pkg::*;
#(
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned MIN_DELTA  = 2,
    parameter int unsigned MAX_DELTA  = 5,
    parameter int unsigned INIT_VALUE = 0,
    parameter logic [15:0] SEED       = 16'hACE1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             start,
    input  logic [15:0]      num_steps,
    input  logic             hold,
`ifdef IVL_UVM_OVL_DELTA_STIM_VIOL_INJ_EN
    input  logic             inj_viol,
    output logic             viol_flag,
`endif
    output logic [WIDTH-1:0] test_expr,
    output logic             valid,
    output logic [WIDTH:0]   delta,
    output logic             busy,
    output logic             done
);

    // ------------------------------------------------------------------
    // Parameter legality
    // ------------------------------------------------------------------
`ifdef IVL_UVM_OVL_DELTA_STIM_VIOL_INJ_EN
    localparam int unsigned MaxMag = MAX_DELTA + 1;
`else
    localparam int unsigned MaxMag = MAX_DELTA;
`endif
    localparam longint unsigned HalfSpan = 64'd1 << (WIDTH - 1);
    localparam longint unsigned FullMax  = (64'd1 << WIDTH) - 64'd1;
    localparam int unsigned     Range    = MAX_DELTA - MIN_DELTA + 1;
    localparam logic [WIDTH-1:0] InitVal = WIDTH'(INIT_VALUE);

    if (WIDTH < 1 || WIDTH > 31) begin : gen_bad_width
        $fatal(1, "WIDTH must be in 1..31");
    end
    if (MIN_DELTA < 1) begin : gen_bad_min
        $fatal(1, "MIN_DELTA must be at least 1");
    end
    if (MAX_DELTA < MIN_DELTA) begin : gen_bad_order
        $fatal(1, "MAX_DELTA must not be below MIN_DELTA");
    end
    // Largest step must fit in half the value span so one direction always fits.
    if (longint'(MaxMag) > HalfSpan) begin : gen_bad_max
        $fatal(1, "largest step magnitude exceeds 2**(WIDTH-1)");
    end
    if (SEED == 16'h0000) begin : gen_bad_seed
        $fatal(1, "SEED must be non-zero");
    end
    if (longint'(INIT_VALUE) > FullMax) begin : gen_bad_init
        $fatal(1, "INIT_VALUE does not fit in WIDTH bits");
    end

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    stim_state_e      state_q, state_d;
    logic [15:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0] test_expr_q, test_expr_d;
    logic             valid_q, valid_d;
    logic [WIDTH:0]   delta_q, delta_d;

    logic [15:0]      lfsr_state;
    logic             step_fire;

    int unsigned      mag_int;
    logic [WIDTH:0]   mag;
    logic [WIDTH:0]   cur_ext;
    logic [WIDTH:0]   up_sum;
    logic [WIDTH:0]   dn_diff;
    logic             up_fits;
    logic             dn_fits;
    logic             go_up;
    logic [WIDTH:0]   step_val;
    logic [WIDTH:0]   step_delta;

    // Only the low byte and the top bit of the LFSR steer a step.
    logic             unused_lfsr_bits;
    assign unused_lfsr_bits = ^lfsr_state[14:8];

    // ------------------------------------------------------------------
    // Step selection
    // ------------------------------------------------------------------
    ivl_uvm_ovl_lfsr16 #(
        .SEED (SEED)
    ) u_lfsr (
        .clock   (clock),
        .reset   (reset),
        .advance (step_fire),
        .state   (lfsr_state)
    );

    // A step fires only in RUN with steps left, enabled and not held.
    assign step_fire = (state_q == StRun) && (cnt_q != 16'd0) && enable && !hold;

    // Magnitude, direction forcing and the resulting value, all in WIDTH+1 bits.
    always_comb begin
        mag_int = MIN_DELTA + (32'(lfsr_state[7:0]) % Range);
`ifdef IVL_UVM_OVL_DELTA_STIM_VIOL_INJ_EN
        if (inj_viol) begin
            mag_int = MAX_DELTA + 1;
        end
`endif
        mag     = (WIDTH + 1)'(mag_int);
        cur_ext = {1'b0, test_expr_q};
        up_sum  = cur_ext + mag;
        dn_diff = cur_ext - mag;
        // Carry/borrow out of the low WIDTH bits marks overflow/underflow.
        up_fits = !up_sum[WIDTH];
        dn_fits = !dn_diff[WIDTH];
        go_up   = lfsr_state[15] ? up_fits : !dn_fits;
        if (go_up) begin
            step_val   = up_sum;
            step_delta = mag;
        end else begin
            step_val   = dn_diff;
            step_delta = {(WIDTH + 1){1'b0}} - mag;
        end
    end

    // ------------------------------------------------------------------
    // Run control
    // ------------------------------------------------------------------
    // Next-state logic for IDLE -> RUN -> DONE -> IDLE and the step counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    cnt_d   = num_steps;
                    state_d = (num_steps != 16'd0) ? StRun : StDone;
                end
            end
            StRun: begin
                // The cycle after the final step closes the run.
                if (cnt_q == 16'd0) begin
                    state_d = StDone;
                end else if (step_fire) begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Registered outputs: a new value and its delta appear together with valid.
    always_comb begin
        test_expr_d = test_expr_q;
        valid_d     = 1'b0;
        delta_d     = '0;
        if (step_fire) begin
            test_expr_d = step_val[WIDTH-1:0];
            valid_d     = 1'b1;
            delta_d     = step_delta;
        end
    end

    // State and output registers with synchronous reset; reset aborts any run.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= 16'd0;
            test_expr_q <= InitVal;
            valid_q     <= 1'b0;
            delta_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            test_expr_q <= test_expr_d;
            valid_q     <= valid_d;
            delta_q     <= delta_d;
        end
    end

`ifdef IVL_UVM_OVL_DELTA_STIM_VIOL_INJ_EN
    logic viol_q;

    // Flags an injected oversize step alongside its valid pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            viol_q <= 1'b0;
        end else begin
            viol_q <= step_fire && inj_viol;
        end
    end

    assign viol_flag = viol_q;
`endif

    assign test_expr = test_expr_q;
    assign valid     = valid_q;
    assign delta     = delta_q;
    assign busy      = (state_q == StRun);
    assign done      = (state_q == StDone);

endmodule

// File: tb/tb_ivl_uvm_ovl_delta_stim_gen.sv
// Directed bench for ivl_uvm_ovl_delta_stim_gen: two instances (INIT_VALUE 0 and 15),
// hand-computed step tables from the 16'hACE1 seed, and a bounded-delta monitor on A.
module tb_ivl_uvm_ovl_delta_stim_gen;

    logic        clock;
    logic        reset;
    logic        enable;
    logic        hold;
    logic        start;
    logic [15:0] num_steps;
    logic        start_b;
    logic [15:0] num_b;

    logic [3:0]  te_a, te_b;
    logic        valid_a, valid_b;
    logic [4:0]  delta_a, delta_b;
    logic        busy_a, busy_b;
    logic        done_a, done_b;
`ifdef IVL_UVM_OVL_DELTA_STIM_VIOL_INJ_EN
    logic        inj_viol;
    logic        viol_a, viol_b;
`endif

    int checks = 0;
    int errors = 0;

    ivl_uvm_ovl_delta_stim_gen #(
        .WIDTH      (4),
        .MIN_DELTA  (2),
        .MAX_DELTA  (5),
        .INIT_VALUE (0),
        .SEED       (16'hACE1)
    ) dut_a (
        .clock     (clock),
        .reset     (reset),
        .enable    (enable),
        .start     (start),
        .num_steps (num_steps),
        .hold      (hold),
`ifdef IVL_UVM_OVL_DELTA_STIM_VIOL_INJ_EN
        .inj_viol  (inj_viol),
        .viol_flag (viol_a),
`endif
        .test_expr (te_a),
        .valid     (valid_a),
        .delta     (delta_a),
        .busy      (busy_a),
        .done      (done_a)
    );

    ivl_uvm_ovl_delta_stim_gen #(
        .WIDTH      (4),
        .MIN_DELTA  (2),
        .MAX_DELTA  (5),
        .INIT_VALUE (15),
        .SEED       (16'hACE1)
    ) dut_b (
        .clock     (clock),
        .reset     (reset),
        .enable    (enable),
        .start     (start_b),
        .num_steps (num_b),
        .hold      (1'b0),
`ifdef IVL_UVM_OVL_DELTA_STIM_VIOL_INJ_EN
        .inj_viol  (1'b0),
        .viol_flag (viol_b),
`endif
        .test_expr (te_b),
        .valid     (valid_b),
        .delta     (delta_b),
        .busy      (busy_b),
        .done      (done_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Bounded-delta monitor on instance A (min 2, max 5); reset jumps are not steps.
    logic [3:0] mon_prev = 4'd0;
    int         ovl_fires = 0;
    int         mon_diff;
    always @(negedge clock) begin
        if (!reset && te_a !== mon_prev) begin
            mon_diff = int'(te_a) - int'(mon_prev);
            if (mon_diff < 0) mon_diff = -mon_diff;
            if (mon_diff < 2 || mon_diff > 5) ovl_fires++;
        end
        mon_prev = te_a;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic int sdelta(input logic [4:0] d);
        return int'($signed(d));
    endfunction

    function automatic logic mag_ok(input int d);
        int a;
        a = (d < 0) ? -d : d;
        return (a >= 2) && (a <= 5);
    endfunction

    // First ten steps from seed 16'hACE1 starting at 0, worked by hand.
    int exp_val [10] = '{3, 5, 3, 1, 5, 0, 5, 8, 10, 6};
    int exp_dlt [10] = '{3, 2, -2, -2, 4, -5, 5, 3, 2, -4};

    int prev;
    int d;
    int k;
    int cur;
    int nb;
    int cyc;

    initial begin
        reset     = 1'b1;
        enable    = 1'b1;
        hold      = 1'b0;
        start     = 1'b1;
        num_steps = 16'd16;
        start_b   = 1'b0;
        num_b     = 16'd0;
`ifdef IVL_UVM_OVL_DELTA_STIM_VIOL_INJ_EN
        inj_viol  = 1'b0;
`endif

        // Reset for two clocks with start held high.
        tick();
        tick();
        check("rst_test_expr", 32'(te_a), 32'd0);
        check("rst_valid", 32'(valid_a), 32'd0);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_done", 32'(done_a), 32'd0);
        check("rst_delta", 32'(delta_a), 32'd0);
        check("rst_b_test_expr", 32'(te_b), 32'd15);
        reset = 1'b0;
        start = 1'b0;
        tick();
        check("rst_start_ignored", 32'(busy_a), 32'd0);

        // 16-step run, every cycle enabled.
        start     = 1'b1;
        num_steps = 16'd16;
        tick();
        check("run16_busy", 32'(busy_a), 32'd1);
        check("run16_no_valid_yet", 32'(valid_a), 32'd0);
        start = 1'b0;
        prev  = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            d = sdelta(delta_a);
            check("run16_valid", 32'(valid_a), 32'd1);
            check("run16_busy_in_run", 32'(busy_a), 32'd1);
            check("run16_delta_vs_diff", 32'(int'(te_a) - prev), 32'(d));
            check("run16_mag_range", 32'(mag_ok(d)), 32'd1);
            if (i < 10) begin
                check("run16_value", 32'(te_a), 32'(exp_val[i]));
                check("run16_delta", 32'(d), 32'(exp_dlt[i]));
            end
            prev = int'(te_a);
        end
        tick();
        check("run16_end_valid", 32'(valid_a), 32'd0);
        check("run16_done", 32'(done_a), 32'd1);
        check("run16_end_busy", 32'(busy_a), 32'd0);
        tick();
        check("run16_done_single", 32'(done_a), 32'd0);
        check("run16_ovl_quiet", 32'(ovl_fires), 32'd0);

        // 10-step run with hold on run cycles 3..6; start pulses there must be ignored.
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        start     = 1'b1;
        num_steps = 16'd10;
        tick();
        check("hold_busy_start", 32'(busy_a), 32'd1);
        start = 1'b0;
        k   = 0;
        cur = 0;
        for (int c = 1; c <= 14; c++) begin
            hold  = (c >= 3 && c <= 6);
            start = hold;
            tick();
            if (hold) begin
                check("hold_no_valid", 32'(valid_a), 32'd0);
                check("hold_value_kept", 32'(te_a), 32'(cur));
                check("hold_delta_zero", 32'(delta_a), 32'd0);
            end else begin
                check("hold_valid", 32'(valid_a), 32'd1);
                check("hold_value", 32'(te_a), 32'(exp_val[k]));
                check("hold_delta", 32'(sdelta(delta_a)), 32'(exp_dlt[k]));
                cur = exp_val[k];
                k++;
            end
            check("hold_busy", 32'(busy_a), 32'd1);
        end
        hold  = 1'b0;
        start = 1'b0;
        tick();
        check("hold_done", 32'(done_a), 32'd1);
        check("hold_end_busy", 32'(busy_a), 32'd0);
        check("hold_end_valid", 32'(valid_a), 32'd0);
        tick();
        check("hold_done_single", 32'(done_a), 32'd0);

        // Zero-step run goes straight to DONE.
        start     = 1'b1;
        num_steps = 16'd0;
        tick();
        start = 1'b0;
        check("zero_done", 32'(done_a), 32'd1);
        check("zero_busy", 32'(busy_a), 32'd0);
        check("zero_valid", 32'(valid_a), 32'd0);
        check("zero_value", 32'(te_a), 32'd6);
        tick();
        check("zero_done_single", 32'(done_a), 32'd0);
        check("zero_valid_after", 32'(valid_a), 32'd0);
        check("zero_value_after", 32'(te_a), 32'd6);
        check("ovl_quiet", 32'(ovl_fires), 32'd0);

        // Instance B from 15: 200 steps with periodic enable drops, no wrap.
        start_b = 1'b1;
        num_b   = 16'd200;
        tick();
        start_b = 1'b0;
        check("b_busy", 32'(busy_b), 32'd1);
        nb   = 0;
        cyc  = 0;
        prev = 15;
        while (nb < 200 && cyc < 400) begin
            enable = ((cyc % 7) != 3);
            tick();
            cyc++;
            if (!enable) begin
                check("b_gated_no_valid", 32'(valid_b), 32'd0);
                check("b_gated_value", 32'(te_b), 32'(prev));
            end else begin
                d = sdelta(delta_b);
                check("b_valid", 32'(valid_b), 32'd1);
                if (nb == 0) begin
                    check("b_first_delta", 32'(d), -32'sd3);
                    check("b_first_value", 32'(te_b), 32'd12);
                end
                check("b_no_wrap", 32'(int'(te_b) - prev), 32'(d));
                check("b_mag_range", 32'(mag_ok(d)), 32'd1);
                prev = int'(te_b);
                nb++;
            end
        end
        enable = 1'b1;
        check("b_budget", 32'(nb), 32'd200);
        tick();
        check("b_done", 32'(done_b), 32'd1);
        check("b_end_valid", 32'(valid_b), 32'd0);
        tick();
        check("b_done_single", 32'(done_b), 32'd0);

`ifdef IVL_UVM_OVL_DELTA_STIM_VIOL_INJ_EN
        // Injected oversize step on step 3, then reset mid-run.
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        k = ovl_fires;
        start     = 1'b1;
        num_steps = 16'd10;
        tick();
        start = 1'b0;
        tick();
        check("inj_step1", 32'(te_a), 32'd3);
        tick();
        check("inj_step2", 32'(te_a), 32'd5);
        inj_viol = 1'b1;
        tick();
        inj_viol = 1'b0;
        check("inj_step3_value", 32'(te_a), 32'd11);
        check("inj_step3_delta", 32'(sdelta(delta_a)), 32'd6);
        check("inj_step3_flag", 32'(viol_a), 32'd1);
        tick();
        check("inj_step4_value", 32'(te_a), 32'd9);
        check("inj_step4_flag", 32'(viol_a), 32'd0);
        reset = 1'b1;
        tick();
        check("inj_reset_value", 32'(te_a), 32'd0);
        check("inj_reset_busy", 32'(busy_a), 32'd0);
        check("inj_reset_done", 32'(done_a), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        check("inj_no_done", 32'(done_a), 32'd0);
        check("inj_ovl_once", 32'(ovl_fires - k), 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
